// File: rtl/codificador_rr_pkg.sv
// Shared constants and FSM state type for the round-robin request encoder.
package codificador_rr_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [0:0] {
        IDLE,
        OFFER
    } state_e;

endpackage

// File: rtl/busca_prioridade.sv
// Combinational round-robin search: first set bit of pending at or above ptr, with wrap.
module busca_prioridade #(
    parameter int unsigned N_REQ = 8,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    logic [PTR_W-1:0] pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        // Candidates in order ptr, ptr+1, ..., wrapping; the first hit is kept.
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = PTR_W'((32'(ptr) + k) % N_REQ);
            if (!found && pending[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/codificador_rr.sv
// Round-robin encoder: latches request pulses and offers one source index at a time downstream.
module codificador_rr #(
    parameter int unsigned N_REQ  = codificador_rr_pkg::N_REQ,
    parameter int unsigned CODE_W = codificador_rr_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic              out_ready,
    output logic [CODE_W-1:0] A,
    output logic              valid,
    output logic [N_REQ-1:0]  pending
);

    import codificador_rr_pkg::*;

    localparam int unsigned PTR_W = $clog2(N_REQ);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] a_q, a_d;
    logic              valid_q, valid_d;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  clr;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  idx;
    logic              found;

    busca_prioridade #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_busca (
        .pending (pending_q),
        .ptr     (ptr_q),
        .idx     (idx),
        .found   (found)
    );

    always_comb begin
        clr = '0;
        if (state_q == OFFER && out_ready) begin
            clr[a_q[PTR_W-1:0]] = 1'b1;
        end
        // A new request on the bit being cleared wins, so that source is served again later.
        pending_d = (pending_q & ~clr) | req;

        state_d = state_q;
        a_d     = a_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    a_d     = CODE_W'(idx);
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    ptr_d   = (a_q[PTR_W-1:0] == PTR_W'(N_REQ - 1)) ? '0
                                                                    : a_q[PTR_W-1:0] + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
        end
    end

    assign A       = a_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_codificador_rr.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs a model.
module tb_codificador_rr;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b0;
    logic [3:0] a;
    logic       valid;
    logic [7:0] pending;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [7:0] m_pend  = 8'h00;
    int         m_ptr   = 0;
    int         m_a     = 0;
    bit         m_valid = 1'b0;

    codificador_rr dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .A         (a),
        .valid     (valid),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: an offer is outstanding or not; when not, the next grant comes from the stored
    // requests seen before this edge, scanning upward from the round-robin pointer.
    always @(posedge clk or posedge rst) begin
        logic [7:0] np;
        int         sel;
        if (rst) begin
            m_pend  <= 8'h00;
            m_ptr   <= 0;
            m_a     <= 0;
            m_valid <= 1'b0;
        end else begin
            np = m_pend;
            if (m_valid && out_ready) np = np & ~(8'h01 << m_a);
            np = np | req;
            if (!m_valid) begin
                sel = -1;
                for (int k = 0; k < N; k++) begin
                    if (sel < 0 && m_pend[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
                end
                if (sel >= 0) begin
                    m_a     <= sel;
                    m_valid <= 1'b1;
                end
            end else if (out_ready) begin
                m_valid <= 1'b0;
                m_ptr   <= (m_a + 1) % N;
            end
            m_pend <= np;
        end
    end

    always @(negedge clk) begin
        chk("cyc_A", 32'(a), 32'(m_a));
        chk("cyc_valid", 32'(valid), 32'(m_valid));
        chk("cyc_pending", 32'(pending), 32'(m_pend));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_a[4] = '{0, 7, 0, 7};

        // Reset then idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_state", {20'h0, a, 3'b0, valid, pending}, 32'h0);
        end

        // Single request: two-edge latency, then accepted
        do_reset();
        req       = 8'h08;
        out_ready = 1'b1;
        tick();
        req = 8'h00;
        chk("single_pend", 32'(pending), 32'h08);
        chk("single_nolat", 32'(valid), 32'h0);
        tick();
        chk("single_valid", 32'(valid), 32'h1);
        chk("single_A", 32'(a), 32'h3);
        tick();
        chk("single_done", {23'h0, valid, pending}, 32'h0);

        // Round robin with pointer wrap
        do_reset();
        req       = 8'h81;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_valid", 32'(valid), 32'h1);
            chk("rr_A", 32'(a), 32'(exp_a[k]));
            chk("rr_model_A", 32'(m_a), 32'(exp_a[k]));
            tick();
            chk("rr_gap", 32'(valid), 32'h0);
        end

        // Backpressure
        do_reset();
        req       = 8'h24;
        out_ready = 1'b0;
        tick();
        req = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {27'h0, valid, a}, 32'h12);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_accept_valid", 32'(valid), 32'h0);
        chk("bp_accept_pend", 32'(pending), 32'h20);
        tick();
        chk("bp_next", {27'h0, valid, a}, 32'h15);
        tick();

        // Set/clear collision on the offered bit
        do_reset();
        req       = 8'h50;
        out_ready = 1'b0;
        tick();
        req = 8'h00;
        tick();
        chk("col_offer", {27'h0, valid, a}, 32'h14);
        out_ready = 1'b1;
        req       = 8'h10;
        tick();
        req = 8'h00;
        chk("col_pend", 32'(pending), 32'h50);
        tick();
        chk("col_other", {27'h0, valid, a}, 32'h16);
        tick();
        tick();
        chk("col_regrant", {27'h0, valid, a}, 32'h14);
        tick();
        chk("col_empty", 32'(pending), 32'h00);

        // Reset mid-offer
        do_reset();
        req       = 8'h40;
        out_ready = 1'b0;
        tick();
        req = 8'h00;
        tick();
        chk("rmo_offer", {27'h0, valid, a}, 32'h16);
        #2;
        rst = 1'b1;
        #1;
        chk("rmo_async", {20'h0, a, 3'b0, valid, pending}, 32'h0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rmo_quiet", 32'(valid), 32'h0);
        end
        req = 8'h01;
        tick();
        req = 8'h00;
        chk("rmo_lat1", 32'(valid), 32'h0);
        tick();
        chk("rmo_lat2", {27'h0, valid, a}, 32'h10);

        // Randomized traffic with occasional asynchronous resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
